// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential modular ALU.
package alu_pkg;

    localparam int ARQ_DEFAULT = 16;

    // Operation codes as presented on contrl.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_SQR = 2'b11
    } op_t;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ADDSUB = 2'b01,
        S_MUL    = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    // True for the two opcodes that run through the bit-serial multiplier.
    function automatic logic is_mul_op(input op_t op);
        return (op == OP_MUL) || (op == OP_SQR);
    endfunction

endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first step of interleaved modular multiplication:
// r' = (2r mod m + bit*a) mod m, with all intermediates kept below 2m.
module mod_mul_step #(
    parameter int ARQ = 16
) (
    input  logic [ARQ-1:0] r,
    input  logic [ARQ-1:0] a,
    input  logic [ARQ-1:0] m,
    input  logic           bit_val,
    output logic [ARQ-1:0] r_next
);

    logic [ARQ:0] m_ext;
    logic [ARQ:0] dbl;
    logic [ARQ:0] dbl_red;
    logic [ARQ:0] sum;
    logic [ARQ:0] sum_red;

    assign m_ext   = {1'b0, m};
    // Doubling r < m gives at most 2m-2, so one subtraction restores r < m.
    assign dbl     = {r, 1'b0};
    assign dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
    // Adding a < m keeps the sum below 2m-1, again needing one subtraction.
    assign sum     = dbl_red + (bit_val ? {1'b0, a} : '0);
    assign sum_red = (sum >= m_ext) ? (sum - m_ext) : sum;
    assign r_next  = sum_red[ARQ-1:0];

endmodule

// File: rtl/seq_mod_alu.sv
// Multi-cycle modular ALU: (d1 op d2) mod d3 for add, sub, mul and square,
// with a start/busy/done handshake. Multiplication is bit-serial, MSB first.
module seq_mod_alu
    import alu_pkg::*;
#(
    parameter int ARQ = ARQ_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     contrl,
    input  logic [ARQ-1:0] d1,
    input  logic [ARQ-1:0] d2,
    input  logic [ARQ-1:0] d3,
    output logic [ARQ-1:0] result,
    output logic           z,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int IW = $clog2(ARQ);

    state_t         state_reg, state_next;
    op_t            op_reg;
    logic [ARQ-1:0] a_reg, b_reg, m_reg, r_reg;
    logic [IW-1:0]  idx_reg;
    logic [ARQ-1:0] result_reg;
    logic           z_reg, err_reg;

    op_t            op_in;
    logic [ARQ-1:0] b_in;
    logic           operands_ok;
    logic           can_accept;
    logic [ARQ-1:0] addsub_val;
    logic [ARQ-1:0] step_out;

    // Square reuses d1 as the second operand, so only d1 is range-checked.
    assign op_in       = op_t'(contrl);
    assign b_in        = (op_in == OP_SQR) ? d1 : d2;
    assign operands_ok = (d3 != '0) && (d1 < d3) && (b_in < d3);
    assign can_accept  = (state_reg == S_IDLE) || (state_reg == S_DONE);

    mod_mul_step #(
        .ARQ(ARQ)
    ) u_step (
        .r      (r_reg),
        .a      (a_reg),
        .m      (m_reg),
        .bit_val(b_reg[idx_reg]),
        .r_next (step_out)
    );

    // Single-cycle modular add/subtract on the latched operands.
    always_comb begin
        logic [ARQ:0] s;
        addsub_val = '0;
        s          = {1'b0, a_reg} + {1'b0, b_reg};
        if (op_reg == OP_SUB) begin
            // Wrap-around arithmetic makes a-b+m exact whenever a < b.
            addsub_val = (a_reg >= b_reg) ? (a_reg - b_reg) : (a_reg - b_reg + m_reg);
        end else begin
            addsub_val = (s >= {1'b0, m_reg}) ? ARQ'(s - {1'b0, m_reg}) : s[ARQ-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                done       = (state_reg == S_DONE);
                state_next = S_IDLE;
                if (start) begin
                    if (!operands_ok) begin
                        state_next = S_DONE;
                    end else if (is_mul_op(op_in)) begin
                        state_next = S_MUL;
                    end else begin
                        state_next = S_ADDSUB;
                    end
                end
            end
            S_ADDSUB: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_MUL: begin
                busy = 1'b1;
                if (idx_reg == '0) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latch, multiplier accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_reg     <= OP_ADD;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            r_reg      <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
            z_reg      <= 1'b1;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start && can_accept) begin
                        op_reg  <= op_in;
                        a_reg   <= d1;
                        b_reg   <= b_in;
                        m_reg   <= d3;
                        r_reg   <= '0;
                        idx_reg <= IW'(ARQ - 1);
                        if (!operands_ok) begin
                            result_reg <= '0;
                            z_reg      <= 1'b1;
                            err_reg    <= 1'b1;
                        end
                    end
                end
                S_ADDSUB: begin
                    result_reg <= addsub_val;
                    z_reg      <= (addsub_val == '0);
                    err_reg    <= 1'b0;
                end
                S_MUL: begin
                    r_reg   <= step_out;
                    idx_reg <= idx_reg - IW'(1);
                    if (idx_reg == '0) begin
                        result_reg <= step_out;
                        z_reg      <= (step_out == '0);
                        err_reg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign z      = z_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_seq_mod_alu.sv
// Self-checking bench for seq_mod_alu: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_seq_mod_alu;

    localparam int ARQ = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     contrl;
    logic [ARQ-1:0] d1, d2, d3;
    logic [ARQ-1:0] result;
    logic           z, busy, done, err;

    int checks = 0;
    int fails  = 0;

    seq_mod_alu #(.ARQ(ARQ)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .contrl(contrl),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .result(result),
        .z     (z),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: modular arithmetic straight from the operation definitions.
    task automatic model(input logic [1:0] op, input longint a, input longint b, input longint m,
                         output logic exp_err, output longint exp_res);
        longint bb;
        bb = (op == 2'b11) ? a : b;
        if (m == 0 || a >= m || bb >= m) begin
            exp_err = 1'b1;
            exp_res = 0;
        end else begin
            exp_err = 1'b0;
            case (op)
                2'b00:   exp_res = (a + bb) % m;
                2'b01:   exp_res = (a + m - bb) % m;
                default: exp_res = (a * bb) % m;
            endcase
        end
    endtask

    // Issue one op (called #1 after an edge, in IDLE or DONE) and check it.
    // Returns #1 after the edge entering DONE. noisy pulses start while busy.
    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] m, input bit noisy, input string tag);
        logic   exp_err;
        longint exp_res;
        int     n, busy_cnt, exp_lat;
        model(op, longint'(a), longint'(b), longint'(m), exp_err, exp_res);
        exp_lat = exp_err ? 0 : (op[1] ? ARQ : 1);
        contrl = op; d1 = a; d2 = b; d3 = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        contrl = 2'($urandom); d1 = 16'($urandom); d2 = 16'($urandom); d3 = 16'($urandom);
        n = 0; busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            if (noisy && busy) begin
                start = 1'($urandom);
                contrl = 2'($urandom); d1 = 16'($urandom); d2 = 16'($urandom); d3 = 16'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        $display("op=%0d d1=%0d d2=%0d d3=%0d -> result=%0d z=%0b err=%0b lat=%0d (%s)",
                 op, a, b, m, result, z, err, n, tag);
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":latency"}, 32'(n), 32'(exp_lat));
        check({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, ":result"}, 32'(result), 32'(exp_res));
        check({tag, ":z"}, 32'(z), 32'(exp_res == 0));
        check({tag, ":err"}, 32'(err), 32'(exp_err));
    endtask

    // Let the design idle; the first cycle confirms done was a single pulse.
    task automatic idle(input int cycles);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        for (int i = 1; i < cycles; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [15:0] ra, rb, rm;
        bit          seen_done;

        rst = 1'b0; start = 1'b0; contrl = 2'b00; d1 = '0; d2 = '0; d3 = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        check("reset:result", 32'(result), 32'd0);
        check("reset:z", 32'(z), 32'd1);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:err", 32'(err), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op(2'b00, 16'd15, 16'd15, 16'd17, 1'b0, "add_15_15_17");
        idle(2);
        do_op(2'b01, 16'd3, 16'd10, 16'd17, 1'b0, "sub_3_10_17");
        idle(1);
        do_op(2'b01, 16'd9, 16'd9, 16'd17, 1'b0, "sub_zero");
        idle(1);
        do_op(2'b10, 16'd16, 16'd27, 16'd237, 1'b0, "mul_16_27_237");
        idle(1);
        do_op(2'b11, 16'd15, 16'd999, 16'd237, 1'b0, "sqr_15_237");
        idle(1);
        do_op(2'b00, 16'd5, 16'd6, 16'd0, 1'b0, "err_m_zero");
        idle(2);
        check("err_holds", 32'(err), 32'd1);
        do_op(2'b00, 16'd20, 16'd1, 16'd17, 1'b0, "err_d1_ge_m");
        idle(1);
        do_op(2'b10, 16'hFFFE, 16'hFFFD, 16'hFFFF, 1'b0, "mul_wide");
        idle(1);

        // Back-to-back: each op is issued in the DONE cycle of the previous one.
        do_op(2'b00, 16'd100, 16'd200, 16'd251, 1'b0, "b2b_a");
        do_op(2'b10, 16'd123, 16'd45, 16'd251, 1'b0, "b2b_b");
        do_op(2'b01, 16'd1, 16'd250, 16'd251, 1'b0, "b2b_c");
        idle(1);

        // start pulses during MUL are ignored.
        do_op(2'b10, 16'd1000, 16'd777, 16'd4099, 1'b1, "mul_noisy");
        idle(1);

        // Reset in the middle of a multiply.
        contrl = 2'b10; d1 = 16'd50; d2 = 16'd60; d3 = 16'd97; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:done", 32'(done), 32'd0);
        check("midrst:result", 32'(result), 32'd0);
        check("midrst:z", 32'(z), 32'd1);
        check("midrst:err", 32'(err), 32'd0);
        rst = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst:quiet", 32'(seen_done), 32'd0);
        do_op(2'b00, 16'd40, 16'd70, 16'd97, 1'b0, "after_reset_add");
        idle(1);

        // Random operations, occasionally with operand violations or gaps.
        for (int t = 0; t < 40; t++) begin
            rop = 2'($urandom);
            rm  = 16'($urandom_range(1, 65535));
            ra  = 16'($urandom % rm);
            rb  = 16'($urandom % rm);
            if ($urandom_range(0, 9) == 0) ra = rm + 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) rm = 16'd0;
            do_op(rop, ra, rb, rm, 1'($urandom), $sformatf("rand_%0d", t));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
